// File: rtl/alu_wb_stage_if.sv
// alu_wb_stage_if: ALU-result / register-file-write handshake bundle for alu_wb_stage.
// Forwarding signals exist only when CPU_WB_FWD_EN is defined.
interface alu_wb_stage_if #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned FLAGS_WIDTH   = 4,
  parameter int unsigned REG_IDX_WIDTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WORD_WIDTH-1:0]    in_data;
  logic [FLAGS_WIDTH-1:0]   in_flags;
  logic [REG_IDX_WIDTH-1:0] in_rd;
  logic                     in_wr_reg;
  logic                     in_wr_flags;
  logic                     flush;
  logic [FLAGS_WIDTH-1:0]   flags_q;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_WIDTH-1:0]    out_data;
  logic [REG_IDX_WIDTH-1:0] out_rd;
  logic                     out_wr_reg;
`ifdef CPU_WB_FWD_EN
  logic                     fwd_valid;
  logic [REG_IDX_WIDTH-1:0] fwd_rd;
  logic [WORD_WIDTH-1:0]    fwd_data;

  modport slave (
    input  in_valid, in_data, in_flags, in_rd, in_wr_reg, in_wr_flags, flush, out_ready,
    output in_ready, flags_q, out_valid, out_data, out_rd, out_wr_reg,
           fwd_valid, fwd_rd, fwd_data
  );
  modport master (
    output in_valid, in_data, in_flags, in_rd, in_wr_reg, in_wr_flags, flush, out_ready,
    input  in_ready, flags_q, out_valid, out_data, out_rd, out_wr_reg,
           fwd_valid, fwd_rd, fwd_data
  );
`else
  modport slave (
    input  in_valid, in_data, in_flags, in_rd, in_wr_reg, in_wr_flags, flush, out_ready,
    output in_ready, flags_q, out_valid, out_data, out_rd, out_wr_reg
  );
  modport master (
    output in_valid, in_data, in_flags, in_rd, in_wr_reg, in_wr_flags, flush, out_ready,
    input  in_ready, flags_q, out_valid, out_data, out_rd, out_wr_reg
  );
`endif
endinterface

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: 2-entry skid buffer between the ALU and the register-file write port,
// plus the architectural flags register feeding the ALU.
// Optional feature macro: CPU_WB_FWD_EN (youngest buffered register write for bypass).
module alu_wb_stage #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned FLAGS_WIDTH   = 4,
  parameter int unsigned REG_IDX_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  alu_wb_stage_if.slave bus
);
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;

  logic [CNT_W-1:0]         r_count;
  logic                     r_head;
  logic                     r_tail;
  logic [WORD_WIDTH-1:0]    r_data [DEPTH];
  logic [REG_IDX_WIDTH-1:0] r_rd   [DEPTH];
  logic                     r_wr   [DEPTH];
  logic [FLAGS_WIDTH-1:0]   r_flags;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake qualifiers come from registered occupancy only; flush cancels both.
  assign w_full  = (r_count == CNT_W'(2));
  assign w_empty = (r_count == CNT_W'(0));
  assign w_push  = bus.in_valid && !w_full && !bus.flush;
  assign w_pop   = !w_empty && bus.out_ready && !bus.flush;

  assign bus.in_ready   = !w_full;
  assign bus.out_valid  = !w_empty;
  assign bus.out_data   = r_data[r_head];
  assign bus.out_rd     = r_rd[r_head];
  assign bus.out_wr_reg = r_wr[r_head];
  assign bus.flags_q    = r_flags;

  // FIFO storage, pointers, occupancy and flags; flags commit at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_flags <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_rd[i]   <= '0;
        r_wr[i]   <= 1'b0;
      end
    end else if (bus.flush) begin
      r_count <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_push) begin
        r_data[r_tail] <= bus.in_data;
        r_rd[r_tail]   <= bus.in_rd;
        r_wr[r_tail]   <= bus.in_wr_reg;
        r_tail         <= ~r_tail;
        if (bus.in_wr_flags) begin
          r_flags <= bus.in_flags;
        end
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

`ifdef CPU_WB_FWD_EN
  logic                     w_young;
  logic                     w_fwd_valid;
  logic [REG_IDX_WIDTH-1:0] w_fwd_rd;
  logic [WORD_WIDTH-1:0]    w_fwd_data;

  // Youngest entry is tail-1; with one entry it coincides with the head.
  assign w_young = ~r_tail;

  // Select the youngest buffered entry that writes a register.
  always_comb begin
    w_fwd_valid = 1'b0;
    w_fwd_rd    = r_rd[r_head];
    w_fwd_data  = r_data[r_head];
    if (!w_empty && r_wr[w_young]) begin
      w_fwd_valid = 1'b1;
      w_fwd_rd    = r_rd[w_young];
      w_fwd_data  = r_data[w_young];
    end else if (w_full && r_wr[r_head]) begin
      w_fwd_valid = 1'b1;
    end
  end

  assign bus.fwd_valid = w_fwd_valid;
  assign bus.fwd_rd    = w_fwd_rd;
  assign bus.fwd_data  = w_fwd_data;
`endif
endmodule
